// File: rtl/key_sched_128_if.sv
// key_sched_128_if: start/key load and round-key handshake between the AES-128
// key schedule generator (slave) and its consumer (master).
interface key_sched_128_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_idx, done
  );

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_idx, done
  );
endinterface

// File: rtl/key_sched_128.sv
// key_sched_128: iterative AES-128 key schedule. Emits round keys 0..10 one at
// a time over rk_valid/rk_ready, computing each next key from the held one
// through a registered four-byte S-box stage.
// Optional macro KEY_SCHED_STALL_EN: when defined, rk_ready backpressure holds
// each key until accepted; when undefined, rk_ready is ignored and keys come
// out at a fixed one-per-two-cycles cadence.

// One-cycle-latency SubWord: four parallel S-box lookups, registered output.
module SubWordStage (
  input  logic        clk,
  input  logic [31:0] i_word,
  output logic [31:0] o_sub
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [31:0] r_sub;

  // Register the byte-wise substitution so the consumer sees it one cycle later.
  always_ff @(posedge clk) begin
    r_sub <= {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
              SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};
  end

  assign o_sub = r_sub;
endmodule

module key_sched_128 #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  key_sched_128_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMIT, CALC, FIN} state_t;

  state_t       r_state;
  state_t       w_stateNext;

  logic [127:0] r_rkOut;
  logic [3:0]   r_rkIdx;
  logic [7:0]   r_rcon;
  logic         r_rkValid;
  logic         r_busy;
  logic         r_done;

  logic [127:0] w_rkOutNext;
  logic [3:0]   w_rkIdxNext;
  logic [7:0]   w_rconNext;
  logic         w_rkValidNext;
  logic         w_busyNext;
  logic         w_doneNext;

  logic         w_accept;
  logic         w_lastRound;
  logic [31:0]  w_rotWord;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_w0;
  logic [31:0]  w_w1;
  logic [31:0]  w_w2;
  logic [31:0]  w_w3;

`ifdef KEY_SCHED_STALL_EN
  assign w_accept = r_rkValid & bus.rk_ready;
`else
  logic w_unusedReady;
  assign w_unusedReady = bus.rk_ready;
  assign w_accept      = r_rkValid;
`endif

  assign w_lastRound = (r_rkIdx == 4'(NUM_ROUNDS));

  // The S-box always looks at RotWord(w3) of the held key, so by CALC its
  // registered output already matches the key being expanded.
  assign w_rotWord = {r_rkOut[23:0], r_rkOut[31:24]};

  SubWordStage u_subWord (
    .clk    (clk),
    .i_word (w_rotWord),
    .o_sub  (w_sub)
  );

  assign w_t  = w_sub ^ {r_rcon, 24'h0};
  assign w_w0 = r_rkOut[127:96] ^ w_t;
  assign w_w1 = r_rkOut[95:64]  ^ w_w0;
  assign w_w2 = r_rkOut[63:32]  ^ w_w1;
  assign w_w3 = r_rkOut[31:0]   ^ w_w2;

  // State register; a reset mid-schedule drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Next state: start only matters in IDLE, CALC only follows an accepted key.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (bus.start) w_stateNext = EMIT;
      EMIT: if (w_accept)  w_stateNext = w_lastRound ? FIN : CALC;
      CALC: w_stateNext = EMIT;
      FIN:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Next values of the key, index, rcon and handshake flags for each state.
  always_comb begin
    w_rkOutNext   = r_rkOut;
    w_rkIdxNext   = r_rkIdx;
    w_rconNext    = r_rcon;
    w_rkValidNext = r_rkValid;
    w_busyNext    = r_busy;
    w_doneNext    = r_done;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_rkOutNext   = bus.key_in;
          w_rkIdxNext   = 4'd0;
          w_rconNext    = 8'h01;
          w_rkValidNext = 1'b1;
          w_busyNext    = 1'b1;
        end
      end
      EMIT: begin
        if (w_accept) begin
          w_rkValidNext = 1'b0;
          if (w_lastRound) begin
            w_busyNext = 1'b0;
            w_doneNext = 1'b1;
          end
        end
      end
      CALC: begin
        w_rkOutNext   = {w_w0, w_w1, w_w2, w_w3};
        w_rkIdxNext   = r_rkIdx + 4'd1;
        w_rconNext    = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        w_rkValidNext = 1'b1;
      end
      FIN: begin
        w_doneNext = 1'b0;
      end
      default: begin
        w_rkValidNext = 1'b0;
      end
    endcase
  end

  // Datapath registers, cleared asynchronously so no partial key survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rkOut   <= 128'h0;
      r_rkIdx   <= 4'd0;
      r_rcon    <= 8'h01;
      r_rkValid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rkOut   <= w_rkOutNext;
      r_rkIdx   <= w_rkIdxNext;
      r_rcon    <= w_rconNext;
      r_rkValid <= w_rkValidNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  assign bus.rk_out   = r_rkOut;
  assign bus.rk_idx   = r_rkIdx;
  assign bus.rk_valid = r_rkValid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_key_sched_128.sv
// tb_key_sched_128: directed self-checking bench for key_sched_128 using the
// FIPS-197 and all-zero key expansions as reference values.
module tb_key_sched_128;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  key_sched_128_if bus();

  key_sched_128 #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef KEY_SCHED_STALL_EN
  localparam bit STALL_BUILD = 1'b1;
`else
  localparam bit STALL_BUILD = 1'b0;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] fipsKeys [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int total = 0;
  int bad   = 0;

  logic [127:0] beatKey [0:15];
  int           beatIdx [0:15];
  int           beatCyc [0:15];
  int           nBeats;
  int           doneCyc;
  int           holdBad;
  int           busyBad;
  bit           timedOut;
  bit           busyAtDone;

  // Drive start for one edge with the given key, beginning at a negedge.
  task automatic startSchedule(input logic [127:0] key);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key;
  endtask

  // Record accepted beats until done (or the cycle budget runs out), optionally
  // stalling on two indices and injecting a stray start at one index.
  task automatic collectBeats(input int stallA, input int stallB, input int stallLen,
                              input int injectIdx, input int maxCycles);
    int           stallCnt;
    int           lastIdx;
    bit           prevHeld;
    logic [127:0] prevOut;
    logic [3:0]   prevIdx;
    bit           injected;
    bit           acc;
    stallCnt = 0; lastIdx = -1; prevHeld = 1'b0; prevOut = '0; prevIdx = '0;
    injected = 1'b0;
    nBeats = 0; doneCyc = -1; holdBad = 0; busyBad = 0; timedOut = 1'b1; busyAtDone = 1'b1;
    for (int c = 1; c <= maxCycles; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        doneCyc    = c;
        busyAtDone = bus.busy;
        timedOut   = 1'b0;
        bus.rk_ready = 1'b1;
        break;
      end
      if (bus.rk_valid) begin
        if (!bus.busy) busyBad++;
        if (prevHeld && (bus.rk_out !== prevOut || bus.rk_idx !== prevIdx)) holdBad++;
        if (int'(bus.rk_idx) != lastIdx) begin
          stallCnt = 0;
          lastIdx  = int'(bus.rk_idx);
        end
        if ((lastIdx == stallA || lastIdx == stallB) && stallCnt < stallLen) begin
          bus.rk_ready = 1'b0;
          stallCnt++;
        end else begin
          bus.rk_ready = 1'b1;
        end
        if (lastIdx == injectIdx && !injected) begin
          bus.start  = 1'b1;
          bus.key_in = '1;
          injected   = 1'b1;
        end
        acc = STALL_BUILD ? bus.rk_ready : 1'b1;
        if (acc) begin
          if (nBeats < 16) begin
            beatKey[nBeats] = bus.rk_out;
            beatIdx[nBeats] = int'(bus.rk_idx);
            beatCyc[nBeats] = c;
          end
          nBeats++;
          prevHeld = 1'b0;
        end else begin
          prevHeld = 1'b1;
          prevOut  = bus.rk_out;
          prevIdx  = bus.rk_idx;
        end
      end else begin
        bus.rk_ready = 1'b1;
        prevHeld     = 1'b0;
      end
    end
    bus.start    = 1'b0;
    bus.rk_ready = 1'b1;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.rk_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.rk_idx !== 4'd0) begin bad++; $display("[TB] FAIL reset_idx: got %0d want 0", bus.rk_idx); end
    total++; if (bus.rk_out !== 128'h0) begin bad++; $display("[TB] FAIL reset_key: got %h want 0", bus.rk_out); end
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rk_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL idle_no_valid: got %0d beats want 0", seen); end
  endtask

  task automatic test_fips();
    startSchedule(FIPS_KEY);
    collectBeats(-1, -1, 0, -1, 200);
    total++; if (timedOut !== 1'b0) begin bad++; $display("[TB] FAIL fips_timeout: got %b want 0", timedOut); end
    total++; if (nBeats !== 11) begin bad++; $display("[TB] FAIL fips_beats: got %0d want 11", nBeats); end
    for (int k = 0; k <= 10 && k < nBeats; k++) begin
      total++; if (beatKey[k] !== fipsKeys[k]) begin bad++; $display("[TB] FAIL fips_key%0d: got %h want %h", k, beatKey[k], fipsKeys[k]); end
      total++; if (beatIdx[k] !== k) begin bad++; $display("[TB] FAIL fips_idx%0d: got %0d want %0d", k, beatIdx[k], k); end
      total++; if (beatCyc[k] !== 1 + 2 * k) begin bad++; $display("[TB] FAIL fips_cyc%0d: got %0d want %0d", k, beatCyc[k], 1 + 2 * k); end
    end
    total++; if (doneCyc !== 22) begin bad++; $display("[TB] FAIL fips_done_cyc: got %0d want 22", doneCyc); end
    total++; if (busyAtDone !== 1'b0) begin bad++; $display("[TB] FAIL fips_busy_at_done: got %b want 0", busyAtDone); end
    total++; if (busyBad !== 0) begin bad++; $display("[TB] FAIL fips_busy_low: got %0d want 0", busyBad); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL fips_done_pulse: got %b want 0", bus.done); end
    total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("[TB] FAIL fips_valid_after: got %b want 0", bus.rk_valid); end
    total++; if (bus.rk_idx !== 4'd10) begin bad++; $display("[TB] FAIL fips_idx_kept: got %0d want 10", bus.rk_idx); end
    total++; if (bus.rk_out !== fipsKeys[10]) begin bad++; $display("[TB] FAIL fips_key_kept: got %h want %h", bus.rk_out, fipsKeys[10]); end
  endtask

  task automatic test_zero_key();
    startSchedule(128'h0);
    collectBeats(-1, -1, 0, -1, 200);
    total++; if (nBeats !== 11) begin bad++; $display("[TB] FAIL zero_beats: got %0d want 11", nBeats); end
    total++; if (beatKey[0] !== 128'h0) begin bad++; $display("[TB] FAIL zero_key0: got %h want 0", beatKey[0]); end
    total++; if (beatKey[1] !== 128'h62636363626363636263636362636363) begin bad++; $display("[TB] FAIL zero_key1: got %h want 62636363626363636263636362636363", beatKey[1]); end
    total++; if (beatKey[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin bad++; $display("[TB] FAIL zero_key10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", beatKey[10]); end
    total++; if (doneCyc !== 22) begin bad++; $display("[TB] FAIL zero_done_cyc: got %0d want 22", doneCyc); end
  endtask

  task automatic test_stall();
    int expDone;
    int expGap;
    expDone = STALL_BUILD ? 32 : 22;
    expGap  = STALL_BUILD ? 7 : 2;
    startSchedule(FIPS_KEY);
    collectBeats(3, 10, 5, -1, 300);
    total++; if (nBeats !== 11) begin bad++; $display("[TB] FAIL stall_beats: got %0d want 11", nBeats); end
    for (int k = 0; k <= 10 && k < nBeats; k++) begin
      total++; if (beatKey[k] !== fipsKeys[k]) begin bad++; $display("[TB] FAIL stall_key%0d: got %h want %h", k, beatKey[k], fipsKeys[k]); end
    end
    total++; if (holdBad !== 0) begin bad++; $display("[TB] FAIL stall_hold: got %0d changes want 0", holdBad); end
    total++; if (beatCyc[3] - beatCyc[2] !== expGap) begin bad++; $display("[TB] FAIL stall_gap3: got %0d want %0d", beatCyc[3] - beatCyc[2], expGap); end
    total++; if (doneCyc !== expDone) begin bad++; $display("[TB] FAIL stall_done_cyc: got %0d want %0d", doneCyc, expDone); end
    total++; if (doneCyc !== beatCyc[10] + 1) begin bad++; $display("[TB] FAIL stall_done_after10: got %0d want %0d", doneCyc, beatCyc[10] + 1); end
  endtask

  task automatic test_start_ignored();
    startSchedule(FIPS_KEY);
    collectBeats(-1, -1, 0, 4, 200);
    total++; if (nBeats !== 11) begin bad++; $display("[TB] FAIL inject_beats: got %0d want 11", nBeats); end
    for (int k = 0; k <= 10 && k < nBeats; k++) begin
      total++; if (beatKey[k] !== fipsKeys[k]) begin bad++; $display("[TB] FAIL inject_key%0d: got %h want %h", k, beatKey[k], fipsKeys[k]); end
    end
    total++; if (doneCyc !== 22) begin bad++; $display("[TB] FAIL inject_done_cyc: got %0d want 22", doneCyc); end
    startSchedule('1);
    collectBeats(-1, -1, 0, -1, 200);
    total++; if (nBeats !== 11) begin bad++; $display("[TB] FAIL ones_beats: got %0d want 11", nBeats); end
    total++; if (beatKey[0] !== {128{1'b1}}) begin bad++; $display("[TB] FAIL ones_key0: got %h want all ones", beatKey[0]); end
    total++; if (beatIdx[0] !== 0) begin bad++; $display("[TB] FAIL ones_idx0: got %0d want 0", beatIdx[0]); end
  endtask

  task automatic test_reset_abort();
    bit found;
    int seen;
    found = 1'b0;
    startSchedule(FIPS_KEY);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.rk_ready = 1'b1;
      if (bus.rk_valid && bus.rk_idx == 4'd6) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("[TB] FAIL abort_reach_idx6: got %b want 1", found); end
    @(negedge clk);
    total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_in_calc: got %b want 0", bus.rk_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.rk_out !== 128'h0) begin bad++; $display("[TB] FAIL abort_key: got %h want 0", bus.rk_out); end
    total++; if (bus.rk_idx !== 4'd0) begin bad++; $display("[TB] FAIL abort_idx: got %0d want 0", bus.rk_idx); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done: got %b want 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rk_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL abort_no_valid: got %0d beats want 0", seen); end
    startSchedule(FIPS_KEY);
    collectBeats(-1, -1, 0, -1, 200);
    total++; if (nBeats !== 11) begin bad++; $display("[TB] FAIL abort_beats: got %0d want 11", nBeats); end
    for (int k = 0; k <= 10 && k < nBeats; k++) begin
      total++; if (beatKey[k] !== fipsKeys[k]) begin bad++; $display("[TB] FAIL abort_key%0d: got %h want %h", k, beatKey[k], fipsKeys[k]); end
    end
    total++; if (doneCyc !== 22) begin bad++; $display("[TB] FAIL abort_done_cyc: got %0d want 22", doneCyc); end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b1;
    test_reset();
    test_fips();
    test_zero_key();
    test_stall();
    test_start_ignored();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
